// File: rtl/sram_ctrl.sv
// Responder side of the CPU memory interface: arbitrates data loads/stores and
// instruction fetches onto one asynchronous 32-bit SRAM, with stall and ack handshake.
module sram_ctrl #(
    parameter int unsigned READ_CYCLES  = 2,
    parameter int unsigned WRITE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ramOp_i,
    input  logic [19:0] dataAddr_i,
    input  logic [31:0] storeData_i,
    input  logic [3:0]  data_be_i,
    input  logic        inst_req_i,
    input  logic [19:0] instAddr_i,
    output logic [31:0] load_data_o,
    output logic [31:0] load_inst_o,
    output logic        data_ack_o,
    output logic        inst_ack_o,
    output logic        stall_o,
    output logic [19:0] sram_addr_o,
    output logic [31:0] sram_data_o,
    output logic        sram_data_oe_o,
    input  logic [31:0] sram_data_i,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [3:0]  sram_be_n_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD_DATA,
        RD_INST,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        ACK
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(READ_CYCLES - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;

    logic w_is_lw;
    logic w_is_sw;
    logic w_data_req;

    assign w_is_lw    = (ramOp_i == 4'h1);
    assign w_is_sw    = (ramOp_i == 4'h2);
    assign w_data_req = w_is_lw | w_is_sw;

    assign stall_o = (w_data_req & ~data_ack_o) | (inst_req_i & ~inst_ack_o);

    // Strobes are computed for the state being entered, so every SRAM pin is a flop output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            load_data_o    <= '0;
            load_inst_o    <= '0;
            data_ack_o     <= 1'b0;
            inst_ack_o     <= 1'b0;
            sram_addr_o    <= '0;
            sram_data_o    <= '0;
            sram_data_oe_o <= 1'b0;
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_be_n_o    <= '1;
        end else begin
            data_ack_o <= 1'b0;
            inst_ack_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_is_lw) begin
                        r_state     <= RD_DATA;
                        r_cnt       <= RD_LOAD;
                        sram_addr_o <= dataAddr_i;
                        sram_ce_n_o <= 1'b0;
                        sram_oe_n_o <= 1'b0;
                        sram_be_n_o <= '0;
                    end else if (w_is_sw) begin
                        r_state        <= WR_SETUP;
                        sram_addr_o    <= dataAddr_i;
                        sram_data_o    <= storeData_i;
                        sram_data_oe_o <= 1'b1;
                        sram_ce_n_o    <= 1'b0;
                        sram_be_n_o    <= ~data_be_i;
                    end else if (inst_req_i) begin
                        r_state     <= RD_INST;
                        r_cnt       <= RD_LOAD;
                        sram_addr_o <= instAddr_i;
                        sram_ce_n_o <= 1'b0;
                        sram_oe_n_o <= 1'b0;
                        sram_be_n_o <= '0;
                    end
                end
                RD_DATA, RD_INST: begin
                    if (r_cnt == 4'd0) begin
                        if (r_state == RD_DATA) begin
                            load_data_o <= sram_data_i;
                            data_ack_o  <= 1'b1;
                        end else begin
                            load_inst_o <= sram_data_i;
                            inst_ack_o  <= 1'b1;
                        end
                        r_state     <= ACK;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        sram_be_n_o <= '1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WR_SETUP: begin
                    r_state     <= WR_PULSE;
                    r_cnt       <= WR_LOAD;
                    sram_we_n_o <= 1'b0;
                end
                WR_PULSE: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= WR_HOLD;
                        sram_we_n_o <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    r_state        <= ACK;
                    data_ack_o     <= 1'b1;
                    sram_data_oe_o <= 1'b0;
                    sram_ce_n_o    <= 1'b1;
                    sram_be_n_o    <= '1;
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
